// File: rtl/acc_tile_pkg.sv
// Shared definitions for the accumulation tile buffer: FSM state codes,
// packed-lane slice helpers and the saturating adder.
package acc_tile_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // MSB index of a lane inside a packed row; lane 0 occupies the top slice.
  function automatic int unsigned lane_msb(input int unsigned lane,
                                           input int unsigned width,
                                           input int unsigned lanes);
    return (lanes - lane) * width - 1;
  endfunction

  // Signed add clipped to a w-bit two's complement range (w <= 63).
  // Returns {clip_flag, 64-bit result}; the caller keeps the low w bits.
  function automatic logic [64:0] sat_add(input logic signed [63:0] a,
                                          input logic signed [63:0] b,
                                          input int unsigned        w);
    logic signed [64:0] s;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    s  = {a[63], a} + {b[63], b};
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -hi - 65'sd1;
    if (s > hi) begin
      return {1'b1, hi[63:0]};
    end else if (s < lo) begin
      return {1'b1, lo[63:0]};
    end
    return {1'b0, s[63:0]};
  endfunction

endpackage

// File: rtl/acc_tile_lane.sv
// One PE column of the accumulation buffer: row storage, write pointer,
// pass counter, lane-done flag and the read-add-write datapath.
// Build option ACC_TILE_SAT_EN: accumulation saturates and flags clipping;
// otherwise it wraps silently.
module acc_tile_lane
  import acc_tile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PASS_W     = 8,
  parameter int unsigned ROW_W      = $clog2(DEPTH + 1),
  parameter int unsigned PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  accum_i,
  input  logic [ROW_W-1:0]      rows_i,
  input  logic [PASS_W-1:0]     passes_i,
  input  logic                  psum_en_i,
  input  logic [DATA_WIDTH-1:0] psum_i,
  input  logic [PTR_W-1:0]      rptr_i,
  output logic [ACC_WIDTH-1:0]  rd_data_o,
  output logic                  lane_done_o,
  output logic                  drop_err_o,
  output logic                  sat_err_o
);

  logic [ACC_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PASS_W-1:0]    pass_q, pass_d;
  logic                 lane_done_q, lane_done_d;

  logic                 wr_en;
  logic                 last_row;
  logic                 last_pass;
  logic [ACC_WIDTH-1:0] psum_ext;
  logic [ACC_WIDTH-1:0] cur;
  logic [ACC_WIDTH-1:0] add_res;
  logic                 add_clip;
  logic [ACC_WIDTH-1:0] wr_data;

`ifdef ACC_TILE_SAT_EN
  logic [64:0] sat_res;
  logic        sat_unused;
`endif

  // Write acceptance, sign extension and the accumulate datapath
  always_comb begin
    wr_en     = psum_en_i & accum_i & ~lane_done_q;
    last_row  = (ROW_W'(wptr_q) == (rows_i - ROW_W'(1)));
    last_pass = (pass_q == (passes_i - PASS_W'(1)));
    psum_ext  = ACC_WIDTH'($signed(psum_i));
    cur       = mem_q[wptr_q];
`ifdef ACC_TILE_SAT_EN
    sat_res    = sat_add(64'($signed(cur)), 64'($signed(psum_ext)), ACC_WIDTH);
    sat_unused = ^sat_res[63:0];
    add_res    = sat_res[ACC_WIDTH-1:0];
    add_clip   = sat_res[64];
`else
    add_res    = cur + psum_ext;
    add_clip   = 1'b0;
`endif
    wr_data    = (pass_q == '0) ? psum_ext : add_res;
    drop_err_o = psum_en_i & ~(accum_i & ~lane_done_q);
    sat_err_o  = wr_en & (pass_q != '0) & add_clip;
  end

  // Pointer / pass / done next-state; a new tile clears the lane
  always_comb begin
    wptr_d      = wptr_q;
    pass_d      = pass_q;
    lane_done_d = lane_done_q;
    if (clear_i) begin
      wptr_d      = '0;
      pass_d      = '0;
      lane_done_d = 1'b0;
    end else if (wr_en) begin
      if (last_row) begin
        wptr_d = '0;
        if (last_pass) begin
          lane_done_d = 1'b1;
        end else begin
          pass_d = pass_q + PASS_W'(1);
        end
      end else begin
        wptr_d = wptr_q + PTR_W'(1);
      end
    end
  end

  // Lane control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      pass_q      <= '0;
      lane_done_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      pass_q      <= pass_d;
      lane_done_q <= lane_done_d;
    end
  end

  // Row storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

  assign rd_data_o   = mem_q[rptr_i];
  assign lane_done_o = lane_done_q;

endmodule

// File: rtl/acc_tile_buffer.sv
// Multi-pass accumulation buffer behind the systolic array. Lanes accumulate
// independently; once every lane is done the tile drains row by row over a
// valid/ready handshake. Build option ACC_TILE_SAT_EN selects saturating
// accumulation (see acc_tile_lane).
module acc_tile_buffer
  import acc_tile_pkg::*;
#(
  parameter int unsigned PE_SIZE    = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PASS_W     = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_i,
  input  logic [$clog2(DEPTH+1)-1:0]      tile_rows_i,
  input  logic [PASS_W-1:0]               passes_i,
  input  logic [PE_SIZE-1:0]              psum_en_i,
  input  logic [DATA_WIDTH*PE_SIZE-1:0]   psum_row_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [ACC_WIDTH*PE_SIZE-1:0]    psum_row_o,
  output logic                            out_last_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            err_o
);

  localparam int unsigned ROW_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]        state_q, state_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [ROW_W-1:0]  rows_q, rows_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic                         cfg_ok;
  logic                         start_ok;
  logic                         all_done;
  logic                         drain_last;
  logic                         drain_fire;
  logic [PE_SIZE-1:0]           lane_done;
  logic [PE_SIZE-1:0]           drop_err;
  logic [PE_SIZE-1:0]           sat_err;
  logic [ACC_WIDTH-1:0]         rd_data [PE_SIZE];
  logic [ACC_WIDTH*PE_SIZE-1:0] row_all;

  for (genvar g = 0; g < PE_SIZE; g++) begin : lane_g
    acc_tile_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .DEPTH      (DEPTH),
      .PASS_W     (PASS_W),
      .ROW_W      (ROW_W),
      .PTR_W      (PTR_W)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (start_ok),
      .accum_i     (state_q == ST_ACCUM),
      .rows_i      (rows_q),
      .passes_i    (passes_q),
      .psum_en_i   (psum_en_i[g]),
      .psum_i      (psum_row_i[lane_msb(g, DATA_WIDTH, PE_SIZE) -: DATA_WIDTH]),
      .rptr_i      (rptr_q),
      .rd_data_o   (rd_data[g]),
      .lane_done_o (lane_done[g]),
      .drop_err_o  (drop_err[g]),
      .sat_err_o   (sat_err[g])
    );
    assign row_all[lane_msb(g, ACC_WIDTH, PE_SIZE) -: ACC_WIDTH] = rd_data[g];
  end

  // Tile FSM, drain pointer, config latch and sticky error
  always_comb begin
    state_d  = state_q;
    rptr_d   = rptr_q;
    rows_d   = rows_q;
    passes_d = passes_q;
    err_d    = err_q;
    done_d   = 1'b0;

    cfg_ok     = (tile_rows_i != '0) && (tile_rows_i <= ROW_W'(DEPTH)) && (passes_i != '0);
    start_ok   = start_i && (state_q == ST_IDLE) && cfg_ok;
    all_done   = &lane_done;
    drain_last = (state_q == ST_DRAIN) && (ROW_W'(rptr_q) == (rows_q - ROW_W'(1)));
    drain_fire = (state_q == ST_DRAIN) && out_ready_i;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d  = ST_ACCUM;
          rows_d   = tile_rows_i;
          passes_d = passes_i;
          rptr_d   = '0;
        end
      end
      ST_ACCUM: begin
        if (all_done) begin
          state_d = ST_DRAIN;
          rptr_d  = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_fire) begin
          if (drain_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            rptr_d = rptr_q + PTR_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A start in IDLE re-arms the flag (set again if the config is bad);
    // any lane fault in the same cycle still wins.
    if (start_i) begin
      err_d = (state_q == ST_IDLE) ? !cfg_ok : 1'b1;
    end
    if (|drop_err || |sat_err) begin
      err_d = 1'b1;
    end
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rptr_q   <= '0;
      rows_q   <= '0;
      passes_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rptr_q   <= rptr_d;
      rows_q   <= rows_d;
      passes_q <= passes_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  // Output drive; data is forced to zero outside DRAIN
  always_comb begin
    out_valid_o = (state_q == ST_DRAIN);
    out_last_o  = drain_last;
    psum_row_o  = (state_q == ST_DRAIN) ? row_all : '0;
    busy_o      = (state_q != ST_IDLE);
    done_o      = done_q;
    err_o       = err_q;
  end

endmodule
